seatbelt_reminder: RTL
======================

// Module: seatbelt_reminder
// PURPOSE
//   Multi-seat, time-sequenced successor to the single-seat combinational seatbelt lamp.
//   Debounces per-seat buckle and occupancy sensors and tracks ignition in a 4-state FSM.
//   Drives the dash lamp (solid while warning, blinking afterwards), a timed chime and a
//   per-seat unbuckled status vector. Sits between the raw cabin sensors and the dash cluster driver.
// PARAMETERS
//   N_SEATS    4   seat count, >=1; seat 0 is the driver, always treated as occupied
//   DEBOUNCE   4   consecutive differing cycles before a filtered sensor bit changes, >=1
//   WARN_CYC   16  cycles of solid lamp + chime per warning episode, >=1
//   BLINK_HALF 8   cycles per lamp half-period in BLINK, >=1
// PORTS
//   clk        in   1        system clock, all state on rising edge
//   reset      in   1        asynchronous, active-high; clears all state
//   ign        in   1        ignition on
//   buckled    in   N_SEATS  raw buckle switches, 1 = buckled
//   occupied   in   N_SEATS  raw seat-occupancy sensors, 1 = occupied; bit 0 ignored
//   sbl        out  1        seatbelt lamp
//   chime      out  1        audible warning enable
//   unbuckled  out  N_SEATS  per-seat violation flags
// BEHAVIOUR
//   Reset (async, active-high): state=OFF, filtered buckled/occupied = 0, all counters = 0,
//     prev_viol = 0; sbl=0, chime=0, unbuckled=0 while reset is high.
//   Debounce: one filter per bit of buckled and occupied.
//     - Counter increments each edge while raw != filtered; clears when raw == filtered.
//     - Filtered bit takes the raw value on the DEBOUNCE-th consecutive differing edge.
//     - A glitch shorter than DEBOUNCE cycles never reaches the filtered value.
//   Per-seat violation: v[i] = ~bkl_f[i] & (occ_f[i] | (i==0)). viol = |v.
//   New violation: newv = |(v & ~prev_viol). prev_viol <= v every edge; prev_viol is 0 in OFF.
//   FSM (registered state; ign=0 has top priority from every state -> OFF next edge):
//     OFF   : ign -> IDLE.
//     IDLE  : viol -> WARN and load wtmr = WARN_CYC-1; otherwise stay in IDLE.
//     WARN  : ~viol -> IDLE.
//             newv -> reload wtmr = WARN_CYC-1 and stay in WARN.
//             wtmr==0 -> BLINK, phase=1, btmr=BLINK_HALF-1.
//             Otherwise wtmr decrements.
//     BLINK : ~viol -> IDLE.
//             newv -> WARN and reload wtmr.
//             Otherwise btmr decrements. At btmr==0, phase toggles and btmr reloads.
//   Priority within a state: ~viol over newv over timer expiry.
//   Outputs (Moore, decoded from registered state):
//     sbl = WARN | (BLINK & phase).
//     chime = WARN.
//     unbuckled = v when state != OFF, else 0.
//   Timing: WARN is held for exactly WARN_CYC cycles absent newv.
//     BLINK lamp: high BLINK_HALF cycles, low BLINK_HALF cycles, repeating.
//   Reset asserted mid-episode: outputs drop immediately (async).
//     After release, the block restarts from OFF with all sensors filtered as unbuckled/unoccupied.
//   Counter widths: $clog2 of (parameter value + 1); no wrap beyond the loaded values.
// TESTING (defaults; edge 0 = first edge after reset release)
//   1 Driver unbuckled, ign=1 from edge 0:
//     IDLE at edge 1, WARN at edge 2; sbl=chime=1 for 16 cycles; unbuckled=4'b0001.
//     Then BLINK: sbl toggles every 8 cycles, chime=0.
//   2 In BLINK, driver buckled (held) -> after 4 edges debounce plus 1 edge, state=IDLE; sbl=chime=0.
//   3 All buckled and idle; passenger 2 occupied then unbuckles:
//     WARN 5 edges later (4 debounce + 1); unbuckled=4'b0100.
//     Seat 3 unbuckled with occupied=0 -> no violation flagged.
//   4 In WARN, seat 1 becomes a new violation at wtmr=3 -> wtmr reloads; WARN lasts 16 more cycles.
//     Repeat with the new violation during BLINK -> returns to WARN.
//   5 Buckle glitch low for 3 cycles while buckled -> no state change, all outputs 0.
//   6 ign drops during WARN -> OFF next edge, outputs 0.
//     Reset pulse mid-BLINK -> outputs 0 asynchronously; scenario 1 timing repeats after release.

Source files
------------

// File: rtl/seatbelt_reminder.sv
// Multi-seat seatbelt reminder. It debounces the buckle and occupancy sensors for each seat and runs
// an OFF/IDLE/WARN/BLINK sequence that drives the dash lamp, the chime and per-seat unbuckled flags.
module seatbelt_reminder #(
  parameter int N_SEATS    = 4,
  parameter int DEBOUNCE   = 4,
  parameter int WARN_CYC   = 16,
  parameter int BLINK_HALF = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ign,
  input  logic [N_SEATS-1:0] buckled,
  input  logic [N_SEATS-1:0] occupied,
  output logic               sbl,
  output logic               chime,
  output logic [N_SEATS-1:0] unbuckled
);

  localparam int NF  = 2 * N_SEATS;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int WTW = $clog2(WARN_CYC + 1);
  localparam int BTW = $clog2(BLINK_HALF + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE - 1);
  localparam logic [WTW-1:0] WARN_LAST  = WTW'(WARN_CYC - 1);
  localparam logic [BTW-1:0] BLINK_LAST = BTW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_IDLE  = 2'd1,
    S_WARN  = 2'd2,
    S_BLINK = 2'd3
  } state_e;

  state_e             state_q;
  logic [WTW-1:0]     wtmr_q;
  logic [BTW-1:0]     btmr_q;
  logic               phase_q;
  logic [N_SEATS-1:0] prev_viol_q;

  // Filter bank. The low half holds the buckle bits and the high half holds the occupancy bits.
  logic [NF-1:0]  raw;
  logic [NF-1:0]  filt_q;
  logic [NF-1:0]  filt_d;
  logic [DBW-1:0] cnt_q [NF];
  logic [DBW-1:0] cnt_d [NF];

  logic [N_SEATS-1:0] bkl_f;
  logic [N_SEATS-1:0] occ_f;
  logic [N_SEATS-1:0] v;
  logic               viol;
  logic               newv;

  // The driver seat is always treated as occupied, so its occupancy input is forced high.
  assign raw = {occupied | N_SEATS'(1), buckled};

  // NOTE: every always_comb output is given a default before any branch, so no latch can be inferred.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NF; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          filt_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign bkl_f = filt_q[N_SEATS-1:0];
  assign occ_f = filt_q[NF-1:N_SEATS];
  assign v     = ~bkl_f & (occ_f | N_SEATS'(1));
  assign viol  = |v;
  assign newv  = |(v & ~prev_viol_q);

  // NOTE: sequential state uses non-blocking assignment only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OFF;
      wtmr_q      <= '0;
      btmr_q      <= '0;
      phase_q     <= 1'b0;
      prev_viol_q <= '0;
      filt_q      <= '0;
      // NOTE: the debounce counters are flops rather than RAM, so they are cleared on reset.
      for (int i = 0; i < NF; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NF; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      // The next state is OFF exactly when ign is low, so the violation history is cleared there.
      prev_viol_q <= ign ? v : '0;

      if (!ign) begin
        state_q <= S_OFF;
      end else begin
        case (state_q)
          S_OFF: state_q <= S_IDLE;
          S_IDLE: begin
            if (viol) begin
              state_q <= S_WARN;
              wtmr_q  <= WARN_LAST;
            end
          end
          S_WARN: begin
            if (!viol) begin
              state_q <= S_IDLE;
            end else if (newv) begin
              wtmr_q <= WARN_LAST;
            end else if (wtmr_q == '0) begin
              state_q <= S_BLINK;
              phase_q <= 1'b1;
              btmr_q  <= BLINK_LAST;
            end else begin
              wtmr_q <= wtmr_q - WTW'(1);
            end
          end
          S_BLINK: begin
            if (!viol) begin
              state_q <= S_IDLE;
            end else if (newv) begin
              state_q <= S_WARN;
              wtmr_q  <= WARN_LAST;
            end else if (btmr_q == '0) begin
              phase_q <= ~phase_q;
              btmr_q  <= BLINK_LAST;
            end else begin
              btmr_q <= btmr_q - BTW'(1);
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  // The outputs decode only registered state, so asserting reset clears them at once.
  assign sbl       = (state_q == S_WARN) | ((state_q == S_BLINK) & phase_q);
  assign chime     = (state_q == S_WARN);
  assign unbuckled = (state_q != S_OFF) ? v : '0;

endmodule
